// File: rtl/exp_unit_ctrl.sv
// exp_unit_ctrl: two-port round-robin sequencer for a shared exponent add/sub
// datapath. Port 0 (multiplier) computes a+b-BIAS and port 1 (divider)
// computes a-b+BIAS. Each op takes two datapath passes. The result saturates,
// and overflow/underflow are flagged.
module exp_unit_ctrl #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EXP_W-1:0] a0,
  input  logic [EXP_W-1:0] b0,
  input  logic             valid0,
  output logic             ready0,
  input  logic [EXP_W-1:0] a1,
  input  logic [EXP_W-1:0] b1,
  input  logic             valid1,
  output logic             ready1,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_id,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  // Two guard bits keep every intermediate sum/difference exact.
  // The headroom is enough because BIAS < 2**EXP_W - 1.
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] MAX_S  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ZERO_S = '0;

  state_t                   state;
  logic [EXP_W-1:0]         a_r, b_r;
  logic                     id_r;
  logic                     last_grant;
  logic signed [EXP_W+1:0]  t_r;

  logic                     grant_id;
  logic signed [EXP_W+1:0]  a_ext, b_ext, t_next, r_next;

  // Arbitration: a sole requester wins, and a tie goes to the port not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_id = valid1;
    if (valid0 && valid1) grant_id = ~last_grant;
    ready0 = (state == IDLE) && valid0 && !grant_id;
    ready1 = (state == IDLE) && valid1 && grant_id;
  end

  // Datapath arithmetic for the two passes, done in signed EXP_W+2 bits.
  always_comb begin
    a_ext  = $signed({2'b00, a_r});
    b_ext  = $signed({2'b00, b_r});
    t_next = id_r ? (a_ext - b_ext) : (a_ext + b_ext);
    r_next = id_r ? (t_r + BIAS_S) : (t_r - BIAS_S);
  end

  assign busy = (state != IDLE);

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= 1'b0;
      t_r        <= '0;
      out_exp    <= '0;
      out_id     <= 1'b0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ready0 || ready1) begin
            a_r        <= grant_id ? a1 : a0;
            b_r        <= grant_id ? b1 : b0;
            id_r       <= grant_id;
            last_grant <= grant_id;
            state      <= PASS1;
          end
        end
        PASS1: begin
          t_r   <= t_next;
          state <= PASS2;
        end
        PASS2: begin
          out_id    <= id_r;
          out_valid <= 1'b1;
          if (r_next >= MAX_S) begin
            out_exp <= '1;
            out_ovf <= 1'b1;
            out_unf <= 1'b0;
          end else if (r_next <= ZERO_S) begin
            out_exp <= '0;
            out_ovf <= 1'b0;
            out_unf <= 1'b1;
          end else begin
            out_exp <= r_next[EXP_W-1:0];
            out_ovf <= 1'b0;
            out_unf <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
